// File: rtl/lc3_isdu_ctrl_if.sv
// Control bundle between the LC-3 sequencer (master) and the datapath/SRAM side (slave).
interface lc3_isdu_ctrl_if;
  logic       Run, Continue;
  logic [3:0] Opcode;
  logic       IR_5, IR_11, BEN;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic [1:0] ADDR2MUX, ALUK;
  logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/lc3_isdu_ctrl.sv
// LC-3 instruction sequencer: Moore FSM for fetch/decode/execute with a memory wait counter.
// Optional PAUSE instruction (opcode 1101) enabled by defining ISDU_PAUSE_EN.
module lc3_isdu_ctrl #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  lc3_isdu_ctrl_if.master bus
);

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32, S01, S05, S09, S00, S22, S12,
    S04, S21, S06, S25, S27, S07, S23, S16
`ifdef ISDU_PAUSE_EN
    , PAUSE_IR1, PAUSE_IR2
`endif
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

  state_t     r_state, w_next;
  logic [2:0] r_wait, w_wait_next;
  logic       r_ir5, r_ir11;
  logic       w_wait_done;

  assign w_wait_done = (r_wait == WAIT_LAST);

  // IR bits are captured in decode so the execute-state mux selects come only from registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= HALTED;
      r_wait  <= '0;
      r_ir5   <= 1'b0;
      r_ir11  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      if (r_state == S32) begin
        r_ir5  <= bus.IR_5;
        r_ir11 <= bus.IR_11;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_wait_next = '0;
    unique case (r_state)
      HALTED: if (bus.Run) w_next = S18;
      S18:    w_next = S33;
      S33:    if (w_wait_done) w_next = S35; else w_wait_next = r_wait + 3'd1;
      S35:    w_next = S32;
      S32: begin
        unique case (bus.Opcode)
          4'b0001: w_next = S01;
          4'b0101: w_next = S05;
          4'b1001: w_next = S09;
          4'b0000: w_next = S00;
          4'b1100: w_next = S12;
          4'b0100: w_next = S04;
          4'b0110: w_next = S06;
          4'b0111: w_next = S07;
`ifdef ISDU_PAUSE_EN
          4'b1101: w_next = PAUSE_IR1;
`endif
          default: w_next = S18;
        endcase
      end
      S01, S05, S09, S22, S12, S21, S27: w_next = S18;
      S00:    w_next = bus.BEN ? S22 : S18;
      S04:    w_next = S21;
      S06:    w_next = S25;
      S25:    if (w_wait_done) w_next = S27; else w_wait_next = r_wait + 3'd1;
      S07:    w_next = S23;
      S23:    w_next = S16;
      S16:    if (w_wait_done) w_next = S18; else w_wait_next = r_wait + 3'd1;
`ifdef ISDU_PAUSE_EN
      PAUSE_IR1: if (!bus.Continue) w_next = PAUSE_IR2;
      PAUSE_IR2: if (bus.Continue)  w_next = S18;
`endif
      default: w_next = HALTED;
    endcase
  end

  logic w_ld_led;

  always_comb begin
    bus.LD_MAR     = 1'b0;
    bus.LD_MDR     = 1'b0;
    bus.LD_IR      = 1'b0;
    bus.LD_BEN     = 1'b0;
    bus.LD_CC      = 1'b0;
    bus.LD_REG     = 1'b0;
    bus.LD_PC      = 1'b0;
    w_ld_led       = 1'b0;
    bus.GatePC     = 1'b0;
    bus.GateMDR    = 1'b0;
    bus.GateALU    = 1'b0;
    bus.GateMARMUX = 1'b0;
    bus.PCMUX      = 2'b00;
    bus.DRMUX      = 1'b0;
    bus.SR1MUX     = 1'b0;
    bus.SR2MUX     = 1'b0;
    bus.ADDR1MUX   = 1'b0;
    bus.ADDR2MUX   = 2'b00;
    bus.ALUK       = 2'b00;
    bus.Mem_CE     = 1'b0;
    bus.Mem_UB     = 1'b0;
    bus.Mem_LB     = 1'b0;
    bus.Mem_OE     = 1'b1;
    bus.Mem_WE     = 1'b1;
    unique case (r_state)
      S18: begin
        bus.GatePC = 1'b1; bus.LD_MAR = 1'b1; bus.LD_PC = 1'b1;
      end
      S33, S25: begin
        bus.Mem_OE = 1'b0; bus.LD_MDR = 1'b1;
      end
      S35: begin
        bus.GateMDR = 1'b1; bus.LD_IR = 1'b1;
      end
      S32: bus.LD_BEN = 1'b1;
      S01, S05, S09: begin
        bus.SR1MUX  = 1'b1;
        bus.SR2MUX  = (r_state == S09) ? 1'b0 : r_ir5;
        bus.ALUK    = (r_state == S01) ? 2'b00 : (r_state == S05) ? 2'b01 : 2'b10;
        bus.GateALU = 1'b1; bus.LD_REG = 1'b1; bus.LD_CC = 1'b1;
      end
      S22: begin
        bus.ADDR2MUX = 2'b10; bus.PCMUX = 2'b10; bus.LD_PC = 1'b1;
      end
      S12: begin
        bus.SR1MUX = 1'b1; bus.ALUK = 2'b11; bus.GateALU = 1'b1;
        bus.PCMUX = 2'b01; bus.LD_PC = 1'b1;
      end
      S04: begin
        bus.GatePC = 1'b1; bus.DRMUX = 1'b1; bus.LD_REG = 1'b1;
      end
      S21: begin
        bus.ADDR1MUX = ~r_ir11;
        bus.SR1MUX   = ~r_ir11;
        bus.ADDR2MUX = r_ir11 ? 2'b11 : 2'b00;
        bus.PCMUX    = 2'b10; bus.LD_PC = 1'b1;
      end
      S06, S07: begin
        bus.SR1MUX = 1'b1; bus.ADDR1MUX = 1'b1; bus.ADDR2MUX = 2'b01;
        bus.GateMARMUX = 1'b1; bus.LD_MAR = 1'b1;
      end
      S27: begin
        bus.GateMDR = 1'b1; bus.LD_REG = 1'b1; bus.LD_CC = 1'b1;
      end
      S23: begin
        bus.ALUK = 2'b11; bus.GateALU = 1'b1; bus.LD_MDR = 1'b1;
      end
      S16: bus.Mem_WE = 1'b0;
`ifdef ISDU_PAUSE_EN
      PAUSE_IR1: w_ld_led = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef ISDU_PAUSE_EN
  assign bus.LD_LED = w_ld_led;
`else
  logic w_unused;
  assign w_unused   = bus.Continue | w_ld_led;
  assign bus.LD_LED = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_isdu_ctrl.sv
// Directed bench for lc3_isdu_ctrl: identifies each state by its full control-output pattern.
module tb_lc3_isdu_ctrl;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  lc3_isdu_ctrl_if bus();
  lc3_isdu_ctrl #(.MEM_WAIT(2)) dut (.Clk(Clk), .Reset(Reset), .bus(bus.master));

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic g_pc, g_mdr, g_alu, g_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic ce, ub, lb, oe, we;
  } ctl_t;

  int n_err = 0;
  int n_chk = 0;
  logic ex_ir5 = 1'b0, ex_ir11 = 1'b0;

  function automatic ctl_t observe();
    ctl_t o;
    o = '{bus.LD_MAR, bus.LD_MDR, bus.LD_IR, bus.LD_BEN, bus.LD_CC, bus.LD_REG, bus.LD_PC, bus.LD_LED,
          bus.GatePC, bus.GateMDR, bus.GateALU, bus.GateMARMUX, bus.PCMUX, bus.DRMUX, bus.SR1MUX,
          bus.SR2MUX, bus.ADDR1MUX, bus.ADDR2MUX, bus.ALUK,
          bus.Mem_CE, bus.Mem_UB, bus.Mem_LB, bus.Mem_OE, bus.Mem_WE};
    return o;
  endfunction

  // Hand-written output table from the state descriptions.
  function automatic ctl_t expect_of(input string st, input logic ir5, input logic ir11);
    ctl_t e;
    e = '0;
    e.oe = 1'b1; e.we = 1'b1;
    case (st)
      "S18": begin e.g_pc = 1; e.ld_mar = 1; e.ld_pc = 1; end
      "S33", "S25": begin e.oe = 0; e.ld_mdr = 1; end
      "S35": begin e.g_mdr = 1; e.ld_ir = 1; end
      "S32": e.ld_ben = 1;
      "S01": begin e.sr1mux = 1; e.sr2mux = ir5; e.aluk = 2'b00; e.g_alu = 1; e.ld_reg = 1; e.ld_cc = 1; end
      "S05": begin e.sr1mux = 1; e.sr2mux = ir5; e.aluk = 2'b01; e.g_alu = 1; e.ld_reg = 1; e.ld_cc = 1; end
      "S09": begin e.sr1mux = 1; e.aluk = 2'b10; e.g_alu = 1; e.ld_reg = 1; e.ld_cc = 1; end
      "S22": begin e.addr2mux = 2'b10; e.pcmux = 2'b10; e.ld_pc = 1; end
      "S12": begin e.sr1mux = 1; e.aluk = 2'b11; e.g_alu = 1; e.pcmux = 2'b01; e.ld_pc = 1; end
      "S04": begin e.g_pc = 1; e.drmux = 1; e.ld_reg = 1; end
      "S21": begin
        e.addr1mux = ~ir11; e.sr1mux = ~ir11; e.addr2mux = ir11 ? 2'b11 : 2'b00;
        e.pcmux = 2'b10; e.ld_pc = 1;
      end
      "S06", "S07": begin e.sr1mux = 1; e.addr1mux = 1; e.addr2mux = 2'b01; e.g_marmux = 1; e.ld_mar = 1; end
      "S27": begin e.g_mdr = 1; e.ld_reg = 1; e.ld_cc = 1; end
      "S23": begin e.aluk = 2'b11; e.g_alu = 1; e.ld_mdr = 1; end
      "S16": e.we = 0;
      "PAUSE1": e.ld_led = 1;
      default: ; // HALTED, S00, PAUSE2: all quiet
    endcase
    return e;
  endfunction

  task automatic chk(input string st);
    ctl_t o, e;
    o = observe();
    e = expect_of(st, ex_ir5, ex_ir11);
    n_chk++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", st, o, e);
    end
    n_chk++;
    assert ((!(o.oe == 1'b0 && o.we == 1'b0) && $onehot0({o.g_pc, o.g_mdr, o.g_alu, o.g_marmux})) === 1'b1)
    else begin
      n_err++;
      $error("FAIL %s_excl: observed oe=%b we=%b gates=%b expected no conflict", st, o.oe, o.we,
             {o.g_pc, o.g_mdr, o.g_alu, o.g_marmux});
    end
  endtask

  task automatic step(input string st);
    @(posedge Clk);
    #1;
    chk(st);
  endtask

  // From S18: fetch with the given IR fields presented, ending after the S32 check.
  task automatic fetch_decode(input logic [3:0] op, input logic ir5, input logic ir11);
    bus.Opcode = op; bus.IR_5 = ir5; bus.IR_11 = ir11;
    ex_ir5 = ir5; ex_ir11 = ir11;
    step("S33"); step("S33"); step("S35"); step("S32");
  endtask

  initial begin
    Reset = 1'b0;
    bus.Run = 1'b0; bus.Continue = 1'b0; bus.Opcode = 4'h0;
    bus.IR_5 = 1'b0; bus.IR_11 = 1'b0; bus.BEN = 1'b0;
    step("HALTED"); step("HALTED");
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) step("HALTED");

    // ADD R1,R1,#1 (0x1261); Run dropped mid-instruction must not matter
    bus.Run = 1'b1;
    step("S18");
    bus.Run = 1'b0;
    fetch_decode(4'h1, 1'b1, 1'b0);
    step("S01"); step("S18");

    // BR not taken, then taken
    bus.BEN = 1'b0;
    fetch_decode(4'h0, 1'b0, 1'b0);
    step("S00"); step("S18");
    bus.BEN = 1'b1;
    fetch_decode(4'h0, 1'b0, 1'b0);
    step("S00"); step("S22"); step("S18");
    bus.BEN = 1'b0;

    // STR 0x7440
    fetch_decode(4'h7, 1'b0, 1'b0);
    step("S07"); step("S23"); step("S16"); step("S16"); step("S18");

    // STR again, reset during the second S16 cycle
    fetch_decode(4'h7, 1'b0, 1'b0);
    step("S07"); step("S23"); step("S16"); step("S16");
    Reset = 1'b0;
    step("HALTED");
    Reset = 1'b1;
    step("HALTED");

    // LDR after reset: read wait must again last exactly two cycles
    bus.Run = 1'b1;
    step("S18");
    fetch_decode(4'h6, 1'b0, 1'b0);
    step("S06"); step("S25"); step("S25"); step("S27"); step("S18");

    // AND register mode, NOT, JMP, JSR, JSRR
    fetch_decode(4'h5, 1'b0, 1'b0);
    step("S05"); step("S18");
    fetch_decode(4'h9, 1'b1, 1'b0);
    step("S09"); step("S18");
    fetch_decode(4'hC, 1'b0, 1'b0);
    step("S12"); step("S18");
    fetch_decode(4'h4, 1'b0, 1'b1);
    step("S04"); step("S21"); step("S18");
    fetch_decode(4'h4, 1'b0, 1'b0);
    step("S04"); step("S21"); step("S18");

    // Reserved opcode behaves as NOP
    fetch_decode(4'hF, 1'b1, 1'b1);
    step("S18");

    // Opcode 1101
    bus.Continue = 1'b1;
    fetch_decode(4'hD, 1'b0, 1'b0);
`ifdef ISDU_PAUSE_EN
    step("PAUSE1"); step("PAUSE1"); step("PAUSE1");
    bus.Continue = 1'b0;
    step("PAUSE2"); step("PAUSE2");
    bus.Continue = 1'b1;
    step("S18");
`else
    step("S18");
`endif
    step("S33");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed sim still running expected finish");
    $fatal(1, "timeout");
  end
endmodule
